// File: rtl/arr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arr_seq_ctrl
// Purpose  : Front-end sequencer for the systolic array.
//            - Loads NUM_CFG configuration words from the host stream.
//            - Writes channels*width*height input words into the single-port
//              input SRAM.
//            - On command, streams the stored words to the array with
//              valid/last flags, then pulses done.
// Ports    : clk, rstn      clock, synchronous active-low reset
//            mode, go       command select and 1-cycle launch pulse (IDLE only)
//            in_valid/in_ready/data_in   host word stream
//            mem_cen/mem_wen/mem_addr/mem_d/mem_q   SRAM port (active-low
//                           enables, read data one cycle after the read cycle)
//            arr_data/arr_valid/arr_last   stream to the array
//            busy, done, err   status (err is sticky until clear or reset)
// Revision : 1.0  initial release
// ============================================================================
module arr_seq_ctrl #(
  parameter int DATA_W    = 8,
  parameter int NUM_CFG   = 8,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 65536
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        mode,
  input  logic              go,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] arr_data,
  output logic              arr_valid,
  output logic              arr_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Product of three config words needs 3*DATA_W bits; the comparison width
  // also has to hold MEM_DEPTH and any pointer value without truncation.
  localparam int TOT_W  = 3 * DATA_W;
  localparam int MAX_W0 = (TOT_W > ADDR_W) ? TOT_W : ADDR_W;
  localparam int CMP_W  = ((MAX_W0 > 32) ? MAX_W0 : 32) + 1;
  localparam int CFG_PW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  cfg [NUM_CFG];
  logic [CFG_PW-1:0]  cfg_ptr;
  logic [ADDR_W-1:0]  ptr;

  // Read pipeline: stage 0 aligns with the address on the SRAM pins,
  // stage 1 with mem_q being valid; arr_* is the register after that.
  logic               rd_v0;
  logic               rd_last0;
  logic               rd_v1;
  logic               rd_last1;

  logic [TOT_W-1:0]   total;
  logic [CMP_W-1:0]   total_c;
  logic [CMP_W-1:0]   depth_c;
  logic               total_bad;
  logic               ptr_last;
  logic               cfg_last;
  logic               beat;

  assign total     = TOT_W'(cfg[1]) * TOT_W'(cfg[2]) * TOT_W'(cfg[3]);
  assign total_c   = CMP_W'(total);
  assign depth_c   = CMP_W'(MEM_DEPTH);
  assign total_bad = (total_c == '0) || (total_c > depth_c);
  assign ptr_last  = (CMP_W'(ptr) == (total_c - CMP_W'(1)));
  assign cfg_last  = (cfg_ptr == CFG_PW'(NUM_CFG - 1));
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      for (int i = 0; i < NUM_CFG; i++) cfg[i] <= '0;
      cfg_ptr   <= '0;
      ptr       <= '0;
      rd_v0     <= 1'b0;
      rd_last0  <= 1'b0;
      rd_v1     <= 1'b0;
      rd_last1  <= 1'b0;
      mem_cen   <= 1'b1;
      mem_wen   <= 1'b1;
      mem_addr  <= '0;
      mem_d     <= '0;
      arr_data  <= '0;
      arr_valid <= 1'b0;
      arr_last  <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // SRAM is idle and done is low unless a state below says otherwise.
      mem_cen   <= 1'b1;
      mem_wen   <= 1'b1;
      done      <= 1'b0;
      rd_v0     <= 1'b0;
      rd_last0  <= 1'b0;

      rd_v1     <= rd_v0;
      rd_last1  <= rd_last0;
      arr_valid <= rd_v1;
      arr_last  <= rd_v1 & rd_last1;
      if (rd_v1) arr_data <= mem_q;

      case (state)
        ST_IDLE: begin
          if (go) begin
            case (mode)
              2'b00: begin
                state    <= ST_CFG;
                cfg_ptr  <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
              end
              2'b01: begin
                if (total_bad) begin
                  err <= 1'b1;
                end else begin
                  state    <= ST_LOAD;
                  ptr      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                end
              end
              2'b10: begin
                if (total_bad) begin
                  err <= 1'b1;
                end else begin
                  state <= ST_RUN;
                  ptr   <= '0;
                  busy  <= 1'b1;
                end
              end
              default: begin
                for (int i = 0; i < NUM_CFG; i++) cfg[i] <= '0;
                cfg_ptr <= '0;
                ptr     <= '0;
                err     <= 1'b0;
              end
            endcase
          end
        end

        ST_CFG: begin
          if (beat) begin
            cfg[cfg_ptr] <= data_in;
            cfg_ptr      <= cfg_ptr + 1'b1;
            if (cfg_last) begin
              state    <= ST_IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end

        ST_LOAD: begin
          if (beat) begin
            mem_cen  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= ptr;
            mem_d    <= data_in;
            ptr      <= ptr + 1'b1;
            if (ptr_last) begin
              state    <= ST_IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          // One read per cycle; when total==MEM_DEPTH the final increment
          // wraps ptr to 0, but the FSM has already left RUN by then.
          mem_cen  <= 1'b0;
          mem_addr <= ptr;
          ptr      <= ptr + 1'b1;
          rd_v0    <= 1'b1;
          rd_last0 <= ptr_last;
          if (ptr_last) state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (arr_valid && arr_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arr_seq_ctrl
// Purpose  : Scoreboard bench for arr_seq_ctrl. Stimulus tasks push expected
//            SRAM writes and array beats into queues; a monitor pops and
//            compares whenever the DUT presents a write or an array beat.
// Revision : 1.0  initial release
// ============================================================================
module tb_arr_seq_ctrl;
  localparam int DW = 8;
  localparam int NC = 8;
  localparam int AW = 16;
  localparam int MD = 65536;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          go = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in = '0;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] arr_data;
  logic          arr_valid;
  logic          arr_last;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  arr_seq_ctrl #(.DATA_W(DW), .NUM_CFG(NC), .ADDR_W(AW), .MEM_DEPTH(MD)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .go(go),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_q(mem_q),
    .arr_data(arr_data), .arr_valid(arr_valid), .arr_last(arr_last),
    .busy(busy), .done(done), .err(err)
  );

  // Single-port SRAM: write or read on a low chip enable, read data next cycle.
  logic [DW-1:0] sram [0:MD-1];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) sram[mem_addr] <= mem_d;
      else          mem_q <= sram[mem_addr];
    end
  end

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } st_t;

  wr_t           wr_q[$];
  st_t           st_q[$];
  logic [DW-1:0] ref_mem [0:MD-1];
  int            cfg_m [NC];
  bit            err_m = 1'b0;
  int            checks = 0;
  int            fails = 0;
  int            done_cnt = 0;
  int            exp_done = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint model_total();
    return longint'(cfg_m[1]) * longint'(cfg_m[2]) * longint'(cfg_m[3]);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    bit prev_v = 1'b0;
    bit prev_lastv = 1'b0;
    wr_t w;
    st_t s;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!mem_cen && !mem_wen) begin
          if (wr_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     mem_addr, mem_d);
          end else begin
            w = wr_q.pop_front();
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_d, w.data);
          end
        end
        if (arr_valid) begin
          if (st_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_arr_beat: got data 0x%0h expected no beat", arr_data);
          end else begin
            s = st_q.pop_front();
            chk("arr_data", arr_data, s.data);
            chk("arr_last", arr_last, s.last);
          end
        end
        if (prev_v && !prev_lastv && !arr_valid) chk("stream_gap", arr_valid, 1);
        if (done || prev_lastv) chk("done_after_last", done, prev_lastv);
        if (done) done_cnt++;
      end
      prev_v     = arr_valid;
      prev_lastv = arr_valid && arr_last;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_mem_cen"},   mem_cen,   1);
    chk({tag, "_mem_wen"},   mem_wen,   1);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_d"},     mem_d,     0);
    chk({tag, "_arr_data"},  arr_data,  0);
    chk({tag, "_arr_valid"}, arr_valid, 0);
    chk({tag, "_arr_last"},  arr_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_err"},       err,       0);
  endtask

  // Issue a go pulse and apply the command rules to the reference model.
  task automatic do_go(input logic [1:0] m, output bit launch);
    longint tot = model_total();
    bit bad = (tot == 0) || (tot > MD);
    mode = m;
    go   = 1'b1;
    @(negedge clk);
    go   = 1'b0;
    launch = 1'b0;
    case (m)
      2'b00: launch = 1'b1;
      2'b01, 2'b10: begin
        launch = !bad;
        if (bad) err_m = 1'b1;
      end
      default: begin
        for (int i = 0; i < NC; i++) cfg_m[i] = 0;
        err_m = 1'b0;
      end
    endcase
    if (m == 2'b10 && launch) begin
      for (longint i = 0; i < tot; i++) st_q.push_back('{data: ref_mem[i], last: (i == tot - 1)});
      exp_done++;
    end
    chk("go_err", err, err_m);
    chk("go_busy", busy, launch);
  endtask

  // Offer words with random in_valid gaps; a beat is in_valid & in_ready.
  task automatic stream_words(input logic [DW-1:0] words[$], input bit is_load);
    int i = 0;
    int guard = 0;
    while (i < words.size() && guard < 5000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      data_in  = words[i];
      if (in_valid && in_ready) begin
        if (is_load) begin
          wr_q.push_back('{addr: AW'(i), data: words[i]});
          ref_mem[i] = words[i];
        end else begin
          cfg_m[i] = int'(words[i]);
        end
        i++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_beats_accepted", i, words.size());
  endtask

  task automatic send_cfg(input int ch, input int w, input int h);
    logic [DW-1:0] q[$];
    bit l;
    q = {8'h00, DW'(ch), DW'(w), DW'(h), 8'h05, 8'h06, 8'h07, 8'h08};
    do_go(2'b00, l);
    stream_words(q, 1'b0);
    chk("busy_after_cfg", busy, 0);
  endtask

  task automatic load_data(input logic [DW-1:0] q[$]);
    bit l;
    do_go(2'b01, l);
    if (l) begin
      stream_words(q, 1'b1);
      repeat (2) @(negedge clk);
      chk("wr_q_drained", wr_q.size(), 0);
    end
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    while (done_cnt < exp_done && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done_cnt, exp_done);
    chk("st_q_drained", st_q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic compute();
    bit l;
    do_go(2'b10, l);
    if (l) wait_done(int'(model_total()) + 20);
  endtask

  initial begin
    logic [DW-1:0] q[$];
    bit l;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] q[$];
    bit l;
    for (int i = 0; i < NC; i++) cfg_m[i] = 0;

    // Power-on reset values.
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rstn = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a load.
    send_cfg(2, 3, 4);
    do_go(2'b01, l);
    in_valid = 1'b1;
    repeat (5) begin
      data_in = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst_mid_load");
    rstn = 1'b1;
    for (int i = 0; i < NC; i++) cfg_m[i] = 0;
    err_m = 1'b0;
    wr_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    do_go(2'b10, l);   // config was cleared by reset: total 0 -> err
    do_go(2'b11, l);

    // Config stream 01..08: ch=2 w=3 h=4, total 24.
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_go(2'b00, l);
    stream_words(q, 1'b0);
    chk("busy_after_cfg8", busy, 0);

    // Load 0x10..0x27 then compute.
    q.delete();
    for (int i = 0; i < 24; i++) q.push_back(DW'(8'h10 + i));
    load_data(q);
    compute();

    // Error cases and clear.
    send_cfg(2, 3, 0);
    do_go(2'b10, l);
    send_cfg(16, 64, 65);
    do_go(2'b10, l);
    do_go(2'b11, l);
    send_cfg(255, 255, 255);
    do_go(2'b01, l);
    do_go(2'b11, l);
    do_go(2'b01, l);   // cleared config: total 0 -> err again
    do_go(2'b11, l);

    // Single-word job.
    send_cfg(1, 1, 1);
    q = {8'hAB};
    load_data(q);
    compute();

    // go and in_valid while streaming are ignored; a second run must match.
    send_cfg(2, 3, 4);
    do_go(2'b10, l);
    repeat (8) begin
      go       = 1'b1;
      mode     = 2'($urandom);
      in_valid = 1'b1;
      data_in  = DW'($urandom);
      chk("run_busy", busy, 1);
      chk("run_in_ready", in_ready, 0);
      @(negedge clk);
    end
    go       = 1'b0;
    in_valid = 1'b0;
    wait_done(60);
    compute();

    // Randomised jobs.
    repeat (3) begin
      send_cfg($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
      q.delete();
      for (longint i = 0; i < model_total(); i++) q.push_back(DW'($urandom));
      load_data(q);
      compute();
    end

    repeat (3) @(negedge clk);
    chk("final_wr_q_empty", wr_q.size(), 0);
    chk("final_st_q_empty", st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
